// File: rtl/clk_div_pkg.sv
// clk_div_pkg: FSM encoding and ratio limits shared by the clock divider.
package clk_div_pkg;

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;

    localparam int DIV_MIN = 2;

    function automatic logic div_ok(input logic [31:0] d);
        return d >= 32'(DIV_MIN);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter and dual-edge output stage.
// Odd ratios OR in a negedge copy to stretch the high phase by half a cycle.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_wrap,
    output logic             o_clk
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_p;
    logic             r_clk_n;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_last;

    assign w_half = i_div >> 1;
    assign w_last = i_div - ONE;
    assign o_wrap = i_run && (r_cnt == w_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_clk_p <= 1'b0;
        end else if (!i_run) begin
            r_cnt   <= '0;
            r_clk_p <= 1'b0;
        end else begin
            r_cnt <= o_wrap ? '0 : r_cnt + ONE;
            if (r_cnt == '0) begin
                r_clk_p <= 1'b1;
            end else if (r_cnt == w_half) begin
                r_clk_p <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_clk_n <= 1'b0;
        end else begin
            r_clk_n <= r_clk_p;
        end
    end

    // Ratio only changes at a wrap, when both phases are already low.
    assign o_clk = i_div[0] ? (r_clk_p | r_clk_n) : r_clk_p;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: ratio handshake, pending register and run/stop FSM.
// Define CLK_DIV_CTRL_PERIOD_CNT_EN to add the 16-bit period_cnt output.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic [CNT_W-1:0] div_active,
    output logic             busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_busy;
    logic             r_err;

    logic w_run;
    logic w_wrap;
    logic w_fire;
    logic w_ok;
    logic w_apply;

    assign w_run   = (r_state == ST_RUN);
    assign w_fire  = cfg_valid && !r_busy;
    assign w_ok    = div_ok(32'(cfg_div));
    // Stopped divider has no boundary to wait for.
    assign w_apply = r_busy && (w_wrap || !w_run);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:  if (enable) r_state <= ST_RUN;
                ST_RUN:  if (w_wrap && !enable) r_state <= ST_OFF;
                default: r_state <= ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= CNT_W'(DIV_RST);
            r_pend <= '0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_fire && !w_ok;
            if (w_apply) begin
                r_div  <= r_pend;
                r_busy <= 1'b0;
            end
            if (w_fire && w_ok) begin
                r_pend <= cfg_div;
                r_busy <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_run  (w_run),
        .i_div  (r_div),
        .o_wrap (w_wrap),
        .o_clk  (clk_out)
    );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] r_period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
        end else if (w_wrap) begin
            r_period <= r_period + 16'd1;
        end
    end

    assign period_cnt = r_period;
`endif

    assign cfg_ready  = !r_busy;
    assign cfg_err    = r_err;
    assign div_active = r_div;
    assign busy       = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: measures clk_out edges in time and compares against
// period = N input clocks and high = N/2 input clocks for the ratio in effect.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    localparam int CNT_W   = 8;
    localparam int DIV_RST = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic [CNT_W-1:0] div_active;
    logic             busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0]      period_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int model_div;

    time t_rise;
    bit  have_rise = 1'b0;
    bit  last_out = 1'b0;
    int  rise_cnt = 0;
    int  per_q[$];
    int  hi_q[$];

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_div    (cfg_div),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .div_active (div_active),
        .busy       (busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Edge monitor: period = rise-to-rise, high = rise-to-fall, in ns.
    always @(clk_out or rst) begin
        if (rst) begin
            have_rise = 1'b0;
            last_out  = 1'b0;
        end else if (clk_out && !last_out) begin
            if (have_rise) per_q.push_back(int'($time - t_rise));
            t_rise    = $time;
            have_rise = 1'b1;
            rise_cnt++;
            last_out  = 1'b1;
        end else if (!clk_out && last_out) begin
            if (have_rise) hi_q.push_back(int'($time - t_rise));
            last_out = 1'b0;
        end
    end

    task automatic wait_rises(input int n, input int budget);
        int target = rise_cnt + n;
        for (int k = 0; k < budget && rise_cnt < target; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (rise_cnt < target) begin
            errors++;
            $display("FAIL wait_rises got %0d want %0d", rise_cnt, target);
        end
    endtask

    task automatic send(input int d);
        bit acc = 1'b0;
        @(negedge clk);
        cfg_div   = CNT_W'(d);
        cfg_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            acc = cfg_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1;
        cfg_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept got 0 want 1 (div %0d)", d);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_div = DIV_RST;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (clk_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_clk_out got %b want 0", clk_out);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cfg_ready);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", cfg_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (div_active !== CNT_W'(DIV_RST)) begin
            errors++;
            $display("FAIL reset_div got %0d want %0d", div_active, DIV_RST);
        end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_pcnt got %0d want 0", period_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_run;
        time t_en;
        int  pb;
        int  hb;
        @(negedge clk);
        enable = 1'b1;
        t_en   = $time + 5;
        wait_rises(1, 20);
        checks++;
        if (t_rise !== t_en + 10) begin
            errors++;
            $display("FAIL first_rise got %0t want %0t", t_rise, t_en + 10);
        end
        pb = per_q.size();
        hb = hi_q.size();
        wait_rises(3, 60);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (per_q[pb+i] !== 10 * model_div) begin
                errors++;
                $display("FAIL run_period[%0d] got %0d want %0d",
                         i, per_q[pb+i], 10 * model_div);
            end
            checks++;
            if (hi_q[hb+i] !== 5 * model_div) begin
                errors++;
                $display("FAIL run_high[%0d] got %0d want %0d",
                         i, hi_q[hb+i], 5 * model_div);
            end
        end
        checks++;
        if (busy !== 1'b0 || div_active !== CNT_W'(model_div)) begin
            errors++;
            $display("FAIL run_state got busy %b div %0d want 0 %0d",
                     busy, div_active, model_div);
        end
    endtask

    task automatic test_ratio_change;
        int old_n;
        int nd;
        int pb;
        int hb;
        int exp_n[3];
        for (int it = 0; it < 4; it++) begin
            old_n = model_div;
            nd = (it == 0) ? 4 : (it == 3) ? 2 : int'($urandom_range(3, 12));
            wait_rises(1, 40);
            pb = per_q.size();
            hb = hi_q.size();
            send(nd);
            checks++;
            if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL chg_busy got busy %b ready %b want 1 0",
                         busy, cfg_ready);
            end
            wait_rises(3, 80);
            exp_n = '{old_n, nd, nd};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (per_q[pb+i] !== 10 * exp_n[i]) begin
                    errors++;
                    $display("FAIL chg_period[%0d] got %0d want %0d",
                             i, per_q[pb+i], 10 * exp_n[i]);
                end
                checks++;
                if (hi_q[hb+i] !== 5 * exp_n[i]) begin
                    errors++;
                    $display("FAIL chg_high[%0d] got %0d want %0d",
                             i, hi_q[hb+i], 5 * exp_n[i]);
                end
            end
            model_div = nd;
            checks++;
            if (busy !== 1'b0 || div_active !== CNT_W'(nd)) begin
                errors++;
                $display("FAIL chg_done got busy %b div %0d want 0 %0d",
                         busy, div_active, nd);
            end
        end
    endtask

    task automatic test_bad_ratio;
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            cfg_div   = CNT_W'(d);
            cfg_valid = 1'b1;
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_pulse got err %b busy %b want 1 0",
                         cfg_err, busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_after got err %b busy %b want 0 0",
                         cfg_err, busy);
            end
            checks++;
            if (div_active !== CNT_W'(model_div)) begin
                errors++;
                $display("FAIL bad_div got %0d want %0d", div_active, model_div);
            end
        end
    endtask

    task automatic test_stop_restart;
        int  rc;
        int  hb;
        int  pb;
        time t_en;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        logic [15:0] pc;
`endif
        send(6);
        for (int k = 0; k < 100 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        model_div = 6;
        checks++;
        if (busy !== 1'b0 || div_active !== CNT_W'(6)) begin
            errors++;
            $display("FAIL stop_load got busy %b div %0d want 0 6",
                     busy, div_active);
        end
        wait_rises(1, 40);
        hb = hi_q.size();
        rc = rise_cnt;
        @(negedge clk);
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        pc = period_cnt;
`endif
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rise_cnt !== rc || clk_out !== 1'b0) begin
            errors++;
            $display("FAIL stop_quiet got rises %0d out %b want %0d 0",
                     rise_cnt, clk_out, rc);
        end
        checks++;
        if (hi_q[hb] !== 30) begin
            errors++;
            $display("FAIL stop_last_high got %0d want 30", hi_q[hb]);
        end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== pc) begin
            errors++;
            $display("FAIL stop_pcnt got %0d want %0d", period_cnt, pc);
        end
`endif
        @(negedge clk);
        enable = 1'b1;
        t_en   = $time + 5;
        wait_rises(1, 20);
        checks++;
        if (t_rise !== t_en + 10) begin
            errors++;
            $display("FAIL restart_rise got %0t want %0t", t_rise, t_en + 10);
        end
        pb = per_q.size();
        hb = hi_q.size();
        wait_rises(2, 40);
        checks++;
        if (per_q[pb] !== 60 || hi_q[hb] !== 30) begin
            errors++;
            $display("FAIL restart_shape got %0d/%0d want 60/30",
                     per_q[pb], hi_q[hb]);
        end
    endtask

    task automatic test_back_to_back;
        int pb;
        int hb;
        int exp_n[3];
        wait_rises(1, 40);
        pb = per_q.size();
        hb = hi_q.size();
        exp_n = '{model_div, 3, 7};
        send(3);
        // Land the next request on the negedge just before the wrap.
        repeat (model_div - 3) @(negedge clk);
        send(7);
        wait_rises(3, 80);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (per_q[pb+i] !== 10 * exp_n[i]) begin
                errors++;
                $display("FAIL b2b_period[%0d] got %0d want %0d",
                         i, per_q[pb+i], 10 * exp_n[i]);
            end
            checks++;
            if (hi_q[hb+i] !== 5 * exp_n[i]) begin
                errors++;
                $display("FAIL b2b_high[%0d] got %0d want %0d",
                         i, hi_q[hb+i], 5 * exp_n[i]);
            end
        end
        model_div = 7;
        checks++;
        if (div_active !== CNT_W'(7) || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got div %0d busy %b want 7 0",
                     div_active, busy);
        end
    endtask

    task automatic test_reset_mid;
        int pb;
        int hb;
        wait_rises(1, 40);
        send(9);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got %b want 0", clk_out);
        end
        checks++;
        if (div_active !== CNT_W'(DIV_RST) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state got div %0d busy %b want %0d 0",
                     div_active, busy, DIV_RST);
        end
        model_div = DIV_RST;
        @(negedge clk);
        rst = 1'b0;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_pcnt got %0d want 0", period_cnt);
        end
`endif
        pb = per_q.size();
        hb = hi_q.size();
        wait_rises(11, 80);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (per_q[pb+i] !== 10 * model_div || hi_q[hb+i] !== 5 * model_div) begin
                errors++;
                $display("FAIL rstmid_shape[%0d] got %0d/%0d want %0d/%0d",
                         i, per_q[pb+i], hi_q[hb+i],
                         10 * model_div, 5 * model_div);
            end
        end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd10) begin
            errors++;
            $display("FAIL pcnt_10 got %0d want 10", period_cnt);
        end
`endif
        checks++;
        if (busy !== 1'b0 || div_active !== CNT_W'(DIV_RST)) begin
            errors++;
            $display("FAIL rstmid_discard got busy %b div %0d want 0 %0d",
                     busy, div_active, DIV_RST);
        end
    endtask

    initial begin
        test_reset;
        test_default_run;
        test_ratio_change;
        test_bad_ratio;
        test_stop_restart;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable integer clock divider controller with 50% duty for both even and odd ratios.
- Accepts new divide ratios over a valid/ready handshake and applies them only at an output-period boundary, so clk_out never glitches or produces a runt pulse.
- Gates the divided clock on and off cleanly.
- Sits between the register/config block and downstream slow-clock consumers; it sequences the counter/dual-edge divider datapath.

Parameters:
CNT_W, 8, width of the divide ratio and period counter; legal ratios are 2 .. 2^CNT_W-1.
DIV_RST, 5, ratio loaded into div_active at reset; must be >= 2.

Ports:
clk  in  1  input clock
rst  in  1  asynchronous reset, active-high
enable  in  1  1 = run divided clock, 0 = stop at next period boundary
cfg_div  in  CNT_W  requested divide ratio
cfg_valid  in  1  request valid
cfg_ready  out  1  controller can accept a request
cfg_err  out  1  one-cycle pulse: request with cfg_div < 2 rejected
clk_out  out  1  divided clock
div_active  out  CNT_W  ratio currently in effect
busy  out  1  a ratio change is pending

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: clk_out=0, cfg_ready=1, cfg_err=0, busy=0, div_active=DIV_RST, cnt=0, FSM=OFF, pending register cleared.
- Counter: cnt counts 0..div_active-1 on posedge clk while in RUN, then wraps to 0. half = div_active>>1 (truncating).
- Output generation:
  - clk_p is set on the posedge where cnt==0 and cleared on the posedge where cnt==half.
  - clk_n is clk_p resampled on negedge clk.
  - Even ratio: clk_out = clk_p, giving N/2 cycles high and N/2 low.
  - Odd ratio: clk_out = clk_p | clk_n, giving exactly N/2 input periods high (half-cycle resolution).
  - Even/odd selection comes from div_active[0], registered with div_active.
- FSM states:
  - OFF: cnt held at 0, clk_p and clk_n held at 0. enable=1 -> RUN. The first clk_out rise is at the posedge following entry to RUN.
  - RUN: free-running divide. At the wrap posedge (cnt==div_active-1):
    - if pending, load div_active from the pending register, clear busy, and go to RUN or OFF per enable;
    - else if enable=0, go to OFF.
  - No other transitions mid-period. enable is sampled only at the wrap.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = !busy.
  - Accepted cfg_div >= 2: latched into the pending register, busy=1 from the next cycle.
  - Accepted cfg_div < 2: not latched; cfg_err pulses for exactly one cycle; busy stays 0.
- Pending request while in OFF: the pending ratio is applied on the next clk posedge, with no wait for a boundary.
- Simultaneous events:
  - Wrap coinciding with an accepting handshake: the current pending value (if any) is applied; the new request becomes pending and is applied at the following wrap.
  - Request equal to div_active: still handshaked, applied as a no-op at the wrap.
- Reset mid-operation: clk_out drops to 0 immediately (asynchronously); any pending request is discarded.
- Width: all counter compares are CNT_W bits unsigned; no overflow is possible because the maximum cnt is div_active-1.

Optional Feature:
Macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined: adds output port period_cnt, 16 bits. It increments by 1 at each wrap posedge in RUN, wraps from 0xFFFF to 0, resets to 0, and holds in OFF.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package clk_div_pkg: FSM state encoding (OFF=2'd0, RUN=2'd1) and constant DIV_MIN=2.
- One natural sub-module, clk_div_core: cnt, clk_p, clk_n and the duty OR, with div_active and run as inputs. clk_div_ctrl owns the FSM, handshake and pending register.

Test Plan:
- Reset, then enable=1 with DIV_RST=5 -> clk_out period 5 clk, high 2.5 clk (negedge rise-to-fall measured), div_active=5, busy=0.
- In RUN at div 5, request cfg_div=4 mid-period -> busy=1, cfg_ready=0 until the wrap; the current 5-cycle period completes, then periods are 4 clk with high 2 clk; no pulse shorter than 2 clk.
- Request cfg_div=1 -> cfg_err high exactly 1 cycle; div_active unchanged; busy stays 0.
- enable 1->0 at cnt=1 of div 6 -> the period finishes (6 clk), then clk_out stays 0 and FSM=OFF. Re-enable -> first rise 1 clk later.
- Request cfg_div=7 arriving on the same cycle as a wrap while pending=3 -> 3 is applied at this wrap and 7 at the next; periods go 3 then 7.
- Assert rst mid-high phase -> clk_out=0 immediately, div_active=DIV_RST, pending discarded. With the macro defined: period_cnt=0, and it counts 10 after 10 periods.
